// File: rtl/seq_detect_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_sched_pkg
//  Description : Shared types and constants for the time-multiplexed "101"
//                sequence-detector scheduler (one-hot context encoding).
//  Revision    : 1.0  initial release
// ============================================================================
package seq_sched_pkg;

    // Bit positions of each state inside the one-hot context word
    localparam int IDX_A = 0;
    localparam int IDX_B = 1;
    localparam int IDX_C = 2;
    localparam int IDX_D = 3;

    // One-hot per-channel detector context; D is the "101 seen" state
    typedef enum logic [3:0] {
        ST_A = 4'b0001,
        ST_B = 4'b0010,
        ST_C = 4'b0100,
        ST_D = 4'b1000
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_detect_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_scheduler_if
//  Description : Channel handshake, detection and statistics bundle between
//                the serial front-end (master) and the scheduler (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface seq_detect_scheduler_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]   ch_valid;
    logic [NCH-1:0]   ch_bit;
    logic [NCH-1:0]   ch_clear;
    logic [NCH-1:0]   ch_ready;
    logic             det_valid;
    logic [CW-1:0]    det_ch;
    logic [CW-1:0]    stat_sel;
    logic [CNT_W-1:0] stat_cnt;

    // Front-end side: presents bits, consumes grants and detections
    modport master (
        output ch_valid, ch_bit, ch_clear, stat_sel,
        input  ch_ready, det_valid, det_ch, stat_cnt
    );

    // Scheduler side
    modport slave (
        input  ch_valid, ch_bit, ch_clear, stat_sel,
        output ch_ready, det_valid, det_ch, stat_cnt
    );

endinterface
`default_nettype wire

// File: rtl/seq_detect_scheduler_next_state.sv
`default_nettype none
// ============================================================================
//  Module      : seq_next_state
//  Description : Pure combinational next-state function of the overlapping
//                "101" detector on a one-hot context. hit flags entry to D.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_next_state
    import seq_sched_pkg::*;
(
    input  state_t cur,
    input  logic   bit_in,
    output state_t nxt,
    output logic   hit
);

    logic [3:0] w_nxt;

    // Sum-of-products per target state; valid because cur is always one-hot
    always_comb begin
        w_nxt        = 4'b0000;
        w_nxt[IDX_A] = ~bit_in & (cur[IDX_A] | cur[IDX_C]);
        w_nxt[IDX_B] =  bit_in & (cur[IDX_A] | cur[IDX_B] | cur[IDX_D]);
        w_nxt[IDX_C] = ~bit_in & (cur[IDX_B] | cur[IDX_D]);
        w_nxt[IDX_D] =  bit_in &  cur[IDX_C];
    end

    assign nxt = state_t'(w_nxt);
    assign hit = w_nxt[IDX_D];

endmodule
`default_nettype wire

// File: rtl/seq_detect_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_scheduler
//  Description : Shares one "101" detector next-state function across NCH
//                serial channels with a round-robin grant, one bit per cycle.
//                Optional per-channel saturating hit counters are enabled by
//                defining SEQ_SCHED_STATS_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_detect_scheduler
    import seq_sched_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
)(
    input  wire                     clk,
    input  wire                     reset,
    seq_detect_scheduler_if.slave   bus
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    state_t          r_ctx [NCH];
    logic [CW-1:0]   r_rr_ptr;
    logic            r_det_valid;
    logic [CW-1:0]   r_det_ch;

    logic [NCH-1:0]  w_elig;
    logic [NCH-1:0]  w_ready;
    logic            w_found;
    logic [CW-1:0]   w_gidx;
    state_t          w_cur;
    state_t          w_nxt;
    logic            w_hit;

    // Cleared channels sit out this cycle; nothing is granted during reset
    assign w_elig = reset ? '0 : (bus.ch_valid & ~bus.ch_clear);

    // Round-robin search: first eligible index at or after the pointer
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        for (int k = 0; k < NCH; k++) begin
            logic [CW:0]   v_sum;
            logic [CW-1:0] v_idx;
            v_sum = {1'b0, r_rr_ptr} + (CW+1)'(k);
            if (v_sum >= (CW+1)'(NCH)) begin
                v_sum = v_sum - (CW+1)'(NCH);
            end
            v_idx = v_sum[CW-1:0];
            if (!w_found && w_elig[v_idx]) begin
                w_found = 1'b1;
                w_gidx  = v_idx;
            end
        end
    end

    // One-hot grant vector
    always_comb begin
        w_ready         = '0;
        w_ready[w_gidx] = w_found;
    end

    assign bus.ch_ready = w_ready;

    // Single shared next-state function, fed by the granted channel
    assign w_cur = r_ctx[w_gidx];

    seq_next_state u_next_state (
        .cur    (w_cur),
        .bit_in (bus.ch_bit[w_gidx]),
        .nxt    (w_nxt),
        .hit    (w_hit)
    );

    // Pointer moves past the granted channel, wrapping explicitly at NCH-1
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (w_found) begin
            r_rr_ptr <= (w_gidx == CW'(NCH-1)) ? '0 : (w_gidx + 1'b1);
        end
    end

    // Per-channel contexts: clear wins, otherwise only the granted one advances
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                r_ctx[i] <= ST_A;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (bus.ch_clear[i]) begin
                    r_ctx[i] <= ST_A;
                end else if (w_found && (w_gidx == CW'(i))) begin
                    r_ctx[i] <= w_nxt;
                end
            end
        end
    end

    // Detection strobe registered on the consuming edge; det_ch is sticky
    always_ff @(posedge clk) begin
        if (reset) begin
            r_det_valid <= 1'b0;
            r_det_ch    <= '0;
        end else begin
            r_det_valid <= w_found & w_hit;
            if (w_found && w_hit) begin
                r_det_ch <= w_gidx;
            end
        end
    end

    assign bus.det_valid = r_det_valid;
    assign bus.det_ch    = r_det_ch;

`ifdef SEQ_SCHED_STATS_EN
    logic [CNT_W-1:0] r_cnt [NCH];
    logic [CNT_W-1:0] w_stat;

    // Saturating hit counters advance on each registered detection strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (r_det_valid && (r_cnt[r_det_ch] != {CNT_W{1'b1}})) begin
            r_cnt[r_det_ch] <= r_cnt[r_det_ch] + 1'b1;
        end
    end

    // Out-of-range selects read as zero
    always_comb begin
        w_stat = '0;
        if ({1'b0, bus.stat_sel} < (CW+1)'(NCH)) begin
            w_stat = r_cnt[bus.stat_sel];
        end
    end

    assign bus.stat_cnt = w_stat;
`else
    logic w_unused_stat_sel;

    assign w_unused_stat_sel = ^bus.stat_sel;
    assign bus.stat_cnt      = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_detect_scheduler
//  Description : Directed self-checking bench for seq_detect_scheduler.
//                Statistics checks compile in when SEQ_SCHED_STATS_EN is set.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_detect_scheduler;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    seq_detect_scheduler_if #(.NCH(4), .CNT_W(8)) bus ();

    seq_detect_scheduler #(.NCH(4), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one bit on a single channel, expect it granted, check detection
    task automatic send(input int ch, input logic b, input logic exp_det);
        bus.ch_valid = 4'b0001 << ch;
        bus.ch_bit   = {4{b}};
        #1;
        chk("ready", 32'(bus.ch_ready), 32'(4'b0001 << ch));
        tick();
        bus.ch_valid = '0;
        chk("det_valid", 32'(bus.det_valid), 32'(exp_det));
        if (exp_det) begin
            chk("det_ch", 32'(bus.det_ch), 32'(ch));
        end
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        reset        = 1'b1;
        bus.ch_valid = '0;
        bus.ch_bit   = '0;
        bus.ch_clear = '0;
        bus.stat_sel = '0;
        tick();
        tick();

        // Reset state: no grant even with all channels valid
        bus.ch_valid = 4'hF;
        #1;
        chk("rst_ready", 32'(bus.ch_ready), 32'h0);
        chk("rst_det_valid", 32'(bus.det_valid), 32'h0);
        chk("rst_det_ch", 32'(bus.det_ch), 32'h0);
        chk("rst_stat", 32'(bus.stat_cnt), 32'h0);
        bus.ch_valid = '0;
        tick();
        reset = 1'b0;

        // Basic detection on ch0
        send(0, 1'b1, 1'b0);
        send(0, 1'b0, 1'b0);
        send(0, 1'b1, 1'b1);
        tick();
        chk("basic_idle", 32'(bus.det_valid), 32'h0);

        // Overlap on ch2: 1,0,1,0,1 -> two detections
        send(2, 1'b1, 1'b0);
        send(2, 1'b0, 1'b0);
        send(2, 1'b1, 1'b1);
        send(2, 1'b0, 1'b0);
        send(2, 1'b1, 1'b1);
        tick();
        chk("ovl_idle", 32'(bus.det_valid), 32'h0);

        // Fairness from reset: all valid, zero bits
        reset = 1'b1;
        tick();
        reset        = 1'b0;
        bus.ch_valid = 4'hF;
        bus.ch_bit   = '0;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_ready", 32'(bus.ch_ready), 32'(4'b0001 << (k % 4)));
            tick();
        end
        bus.ch_valid = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("rr_ch3", 32'(bus.ch_ready), 32'h8);
            chk("rr_nodet", 32'(bus.det_valid), 32'h0);
            tick();
        end
        bus.ch_valid = '0;

        // Context isolation: ch1 1,0 interleaved with ch2 1, then ch1 1
        send(1, 1'b1, 1'b0);
        send(2, 1'b1, 1'b0);
        send(1, 1'b0, 1'b0);
        send(1, 1'b1, 1'b1);
        // ch2 must still be in B: 0 then 1 completes a detection
        send(2, 1'b0, 1'b0);
        send(2, 1'b1, 1'b1);

        // Clear mid-sequence on ch0 (ch0 is in A)
        send(0, 1'b1, 1'b0);
        send(0, 1'b0, 1'b0);
        bus.ch_valid = 4'b0001;
        bus.ch_clear = 4'b0001;
        bus.ch_bit   = 4'hF;
        #1;
        chk("clr_ready", 32'(bus.ch_ready), 32'h0);
        tick();
        bus.ch_clear = '0;
        bus.ch_valid = '0;
        chk("clr_det", 32'(bus.det_valid), 32'h0);
        send(0, 1'b1, 1'b0);

        // Reset mid-sequence on ch0 (ch0 is in B)
        send(0, 1'b0, 1'b0);
        reset        = 1'b1;
        bus.ch_valid = 4'b0001;
        bus.ch_bit   = 4'hF;
        #1;
        chk("rst2_ready", 32'(bus.ch_ready), 32'h0);
        tick();
        reset        = 1'b0;
        bus.ch_valid = '0;
        chk("rst2_det", 32'(bus.det_valid), 32'h0);
        send(0, 1'b1, 1'b0);

        // Multiple clears: drive ch1 and ch2 into C, clear both together
        send(1, 1'b1, 1'b0);
        send(1, 1'b0, 1'b0);
        send(2, 1'b1, 1'b0);
        send(2, 1'b0, 1'b0);
        bus.ch_valid = 4'b0110;
        bus.ch_clear = 4'b0010;
        #1;
        chk("clr_partial", 32'(bus.ch_ready), 32'h4);
        bus.ch_clear = 4'b0110;
        #1;
        chk("clr_multi", 32'(bus.ch_ready), 32'h0);
        tick();
        bus.ch_clear = '0;
        bus.ch_valid = '0;
        send(1, 1'b1, 1'b0);
        send(2, 1'b1, 1'b0);

`ifdef SEQ_SCHED_STATS_EN
        // 300 detections on ch1 from state A; counter saturates at 255
        reset = 1'b1;
        tick();
        reset = 1'b0;
        send(1, 1'b1, 1'b0);
        for (int k = 0; k < 300; k++) begin
            send(1, 1'b0, 1'b0);
            send(1, 1'b1, 1'b1);
        end
        tick();
        bus.stat_sel = 2'd1;
        #1;
        chk("stat_ch1", 32'(bus.stat_cnt), 32'd255);
        bus.stat_sel = 2'd0;
        #1;
        chk("stat_ch0", 32'(bus.stat_cnt), 32'd0);
        bus.ch_clear = 4'b0010;
        tick();
        bus.ch_clear = '0;
        bus.stat_sel = 2'd1;
        #1;
        chk("stat_after_clr", 32'(bus.stat_cnt), 32'd255);
`else
        bus.stat_sel = 2'd2;
        #1;
        chk("stat_tied", 32'(bus.stat_cnt), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
